line_buffer_writer: RTL and testbench

- Transmit side of the LineBuffer write interface.
- Accepts a valid/ready pixel stream from the input DMA or the previous layer, and emits per-row write beats (`lb_we`, `lb_wr_addr`, `lb_data`), then a one-cycle `lb_eol` strobe.
- Counts rows and columns, flags malformed lines, and pulses `frame_done` after the last row of a frame.
- Sits directly upstream of LineBuffer in each convolution stage.

---
 rtl/cnn_lb_pkg.sv | 18 +
 rtl/lb_pos_counter.sv | 46 ++++
 rtl/line_buffer_writer.sv | 206 ++++++++++++++++++++
 tb/tb_line_buffer_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_lb_pkg.sv
// Shared LineBuffer constants and the writer state encoding.
// Imported by line_buffer_writer and lb_pos_counter.
package cnn_lb_pkg;

    localparam int LB_ADDR_WIDTH = 14;
    localparam int LB_DATA_WIDTH = 16;

    // PAD_PRE/PAD_POST are reachable only when LINE_BUFFER_WRITER_ZERO_PAD_EN is defined.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        PAD_PRE  = 3'd2,
        PAD_POST = 3'd3,
        EOL      = 3'd4,
        DONE     = 3'd5
    } lb_wr_state_e;

endpackage

// File: rtl/lb_pos_counter.sv
// Column/row position counter pair for the LineBuffer writer.
// The column wraps at COL_LAST; the row counter runs up to the frame size.
module lb_pos_counter
    import cnn_lb_pkg::*;
#(
    parameter int COL_WIDTH = LB_ADDR_WIDTH,
    parameter int ROW_WIDTH = 5,
    parameter int COL_LAST  = 99,
    parameter int ROW_LAST  = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 col_inc,
    input  logic                 col_clr,
    input  logic                 row_inc,
    input  logic                 row_clr,
    output logic [COL_WIDTH-1:0] col,
    output logic [ROW_WIDTH-1:0] row,
    output logic                 col_tc,
    output logic                 row_tc
);

    assign col_tc = (col == COL_WIDTH'(COL_LAST));
    assign row_tc = (row == ROW_WIDTH'(ROW_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            // Clear wins over increment so an early line end restarts at column 0.
            if (col_clr || (col_inc && col_tc)) begin
                col <= '0;
            end else if (col_inc) begin
                col <= col + 1'b1;
            end

            if (row_clr) begin
                row <= '0;
            end else if (row_inc) begin
                row <= row + 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_buffer_writer.sv
// Transmit side of the LineBuffer write port: pixel stream in, per-row write beats plus eol out.
// Optional zero padding of each row with LINE_BUFFER_WRITER_ZERO_PAD_EN.
module line_buffer_writer
    import cnn_lb_pkg::*;
#(
    parameter int DATA_WIDTH = LB_DATA_WIDTH,
    parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
    parameter int LINE_WIDTH = 100,
    parameter int NUM_ROWS   = 20,
    parameter int PAD        = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_last,
    input  logic                             lb_ready,
    output logic                             lb_we,
    output logic [ADDR_WIDTH-1:0]            lb_wr_addr,
    output logic [DATA_WIDTH-1:0]            lb_data,
    output logic                             lb_eol,
    output logic [$clog2(NUM_ROWS+1)-1:0]    row_count,
    output logic                             frame_done,
    output logic                             err_len
);

    localparam int ROW_WIDTH = $clog2(NUM_ROWS + 1);
`ifdef LINE_BUFFER_WRITER_ZERO_PAD_EN
    localparam int LEAD = PAD;
    localparam lb_wr_state_e ROW_START = PAD_PRE;
`else
    // Without padding PAD has no effect on the column layout.
    localparam int LEAD = 0 * PAD;
    localparam lb_wr_state_e ROW_START = WRITE;
`endif
    localparam int PIX_LAST = LEAD + LINE_WIDTH - 1;
    localparam int COL_LAST = PIX_LAST + LEAD;

    lb_wr_state_e state;

    logic [ADDR_WIDTH-1:0] col;
    logic                  col_tc;
    logic                  row_tc;
    logic                  col_inc;
    logic                  col_clr;
    logic                  row_inc;
    logic                  row_clr;
    logic                  accept;
    logic                  at_pix_last;
    logic                  line_end;
    logic                  len_bad;

`ifdef LINE_BUFFER_WRITER_ZERO_PAD_EN
    logic [ADDR_WIDTH-1:0] pad_cnt;
    logic                  pad_last;
    logic                  post_end;

    assign pad_last    = (pad_cnt == ADDR_WIDTH'(PAD - 1));
    assign post_end    = pad_last || col_tc;
    assign at_pix_last = (col == ADDR_WIDTH'(PIX_LAST));
    // IDLE only waits for the first pixel here; the leading pad must be written before it is taken.
    assign s_ready     = lb_ready && (state == WRITE);
`else
    assign at_pix_last = col_tc;
    assign s_ready     = lb_ready && ((state == WRITE) || (state == IDLE));
`endif

    // s_valid && s_ready is a transfer; s_ready never depends on s_valid.
    assign accept   = s_valid && s_ready;
    assign line_end = accept && (at_pix_last || s_last);
    assign len_bad  = accept && (s_last != at_pix_last);

    always_comb begin
        col_inc = 1'b0;
        col_clr = 1'b0;
        row_inc = 1'b0;
        row_clr = 1'b0;
        if (lb_ready) begin
            case (state)
`ifdef LINE_BUFFER_WRITER_ZERO_PAD_EN
                WRITE: col_inc = accept;
                PAD_PRE: col_inc = 1'b1;
                PAD_POST: begin
                    col_inc = 1'b1;
                    col_clr = post_end;
                end
`else
                IDLE, WRITE: begin
                    col_inc = accept;
                    col_clr = line_end;
                end
`endif
                EOL: begin
                    row_inc = 1'b1;
                    col_clr = 1'b1;
                end
                DONE: row_clr = 1'b1;
                default: ;
            endcase
        end
    end

    lb_pos_counter #(
        .COL_WIDTH (ADDR_WIDTH),
        .ROW_WIDTH (ROW_WIDTH),
        .COL_LAST  (COL_LAST),
        .ROW_LAST  (NUM_ROWS - 1)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .col_inc (col_inc),
        .col_clr (col_clr),
        .row_inc (row_inc),
        .row_clr (row_clr),
        .col     (col),
        .row     (row_count),
        .col_tc  (col_tc),
        .row_tc  (row_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lb_we      <= 1'b0;
            lb_wr_addr <= '0;
            lb_data    <= '0;
            lb_eol     <= 1'b0;
            frame_done <= 1'b0;
            err_len    <= 1'b0;
`ifdef LINE_BUFFER_WRITER_ZERO_PAD_EN
            pad_cnt    <= '0;
`endif
        end else begin
            lb_we      <= 1'b0;
            lb_eol     <= 1'b0;
            frame_done <= 1'b0;
            if (len_bad) begin
                err_len <= 1'b1;
            end
            // A low lb_ready freezes the FSM, so a due eol is deferred rather than lost.
            if (lb_ready) begin
                case (state)
`ifdef LINE_BUFFER_WRITER_ZERO_PAD_EN
                    IDLE: begin
                        if (s_valid) begin
                            state <= PAD_PRE;
                        end
                    end
                    PAD_PRE: begin
                        lb_we      <= 1'b1;
                        lb_wr_addr <= col;
                        lb_data    <= '0;
                        if (pad_last) begin
                            pad_cnt <= '0;
                            state   <= WRITE;
                        end else begin
                            pad_cnt <= pad_cnt + 1'b1;
                        end
                    end
                    WRITE: begin
                        if (accept) begin
                            lb_we      <= 1'b1;
                            lb_wr_addr <= col;
                            lb_data    <= s_data;
                            if (line_end) begin
                                state <= PAD_POST;
                            end
                        end
                    end
                    PAD_POST: begin
                        lb_we      <= 1'b1;
                        lb_wr_addr <= col;
                        lb_data    <= '0;
                        if (post_end) begin
                            pad_cnt <= '0;
                            state   <= EOL;
                        end else begin
                            pad_cnt <= pad_cnt + 1'b1;
                        end
                    end
`else
                    IDLE, WRITE: begin
                        if (accept) begin
                            lb_we      <= 1'b1;
                            lb_wr_addr <= col;
                            lb_data    <= s_data;
                            state      <= line_end ? EOL : WRITE;
                        end
                    end
`endif
                    EOL: begin
                        lb_eol <= 1'b1;
                        state  <= row_tc ? DONE : ROW_START;
                    end
                    DONE: begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_writer.sv
// Self-checking bench for line_buffer_writer (default build, no padding).
// Scoreboard of expected write/eol/frame_done events filled by the driver.
module tb_line_buffer_writer;

    localparam int DW = 16;
    localparam int AW = 14;
    localparam int LW = 100;
    localparam int NR = 20;
    localparam int RW = $clog2(NR + 1);
    localparam int IW = 2 + AW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          lb_ready;
    logic          lb_we;
    logic [AW-1:0] lb_wr_addr;
    logic [DW-1:0] lb_data;
    logic          lb_eol;
    logic [RW-1:0] row_count;
    logic          frame_done;
    logic          err_len;

    line_buffer_writer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .NUM_ROWS   (NR),
        .PAD        (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .lb_ready   (lb_ready),
        .lb_we      (lb_we),
        .lb_wr_addr (lb_wr_addr),
        .lb_data    (lb_data),
        .lb_eol     (lb_eol),
        .row_count  (row_count),
        .frame_done (frame_done),
        .err_len    (err_len)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: item = {kind, addr, data}; kind 0 write, 1 eol, 2 frame_done
    logic [IW-1:0] exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_col;
    int   m_row;
    logic m_err;
    bit   rand_stall = 1'b0;
    int   row_cyc[NR];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // output monitor
    always @(negedge clk) begin
        logic [IW-1:0] obs;
        int n_ev;
        n_ev = int'(lb_we) + int'(lb_eol) + int'(frame_done);
        if (n_ev > 1) check("one_event", n_ev, 1);
        if (n_ev > 0) begin
            if (lb_we) obs = {2'd0, lb_wr_addr, lb_data};
            else if (lb_eol) obs = {2'd1, {(AW+DW){1'b0}}};
            else obs = {2'd2, {(AW+DW){1'b0}}};
            if (exp_q.size() == 0) check("unexpected_event", obs, {IW{1'b1}});
            else check("event", obs, exp_q.pop_front());
        end
    end

    // driver tasks (all called at a negedge)
    task automatic stall_cycles(input int n);
        lb_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("stall_ready", s_ready, 0);
            @(posedge clk);
            @(negedge clk);
            check("stall_we", lb_we, 0);
            check("stall_eol", lb_eol, 0);
        end
        lb_ready = 1'b1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        bit acc;
        int waited;
        waited  = 0;
        acc     = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            #1;
            acc = s_ready;
            if (acc && m_col == 0) check("row_count", row_count, m_row);
            @(posedge clk);
            if (acc) break;
            waited++;
            if (waited > 20) begin
                check("handshake_timeout", 1, 0);
                break;
            end
            @(negedge clk);
        end
        if (acc) begin
            exp_q.push_back({2'd0, AW'(m_col), d});
            if (last != (m_col == LW - 1)) m_err = 1'b1;
            if (last || m_col == LW - 1) begin
                exp_q.push_back({2'd1, {(AW+DW){1'b0}}});
                m_col = 0;
                m_row++;
                if (m_row == NR) begin
                    exp_q.push_back({2'd2, {(AW+DW){1'b0}}});
                    m_row = 0;
                end
            end else begin
                m_col++;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_we", lb_we, 0);
        check("mid_reset_eol", lb_eol, 0);
        check("mid_reset_done", frame_done, 0);
        check("mid_reset_rows", row_count, 0);
        check("mid_reset_err", err_len, 0);
        check("mid_reset_addr", lb_wr_addr, 0);
        check("mid_reset_data", lb_data, 0);
        check("mid_reset_q", exp_q.size(), 0);
        reset = 1'b0;
        m_col = 0;
        m_row = 0;
        m_err = 1'b0;
    endtask

    task automatic run_frame(input bit rnd, input int short_row, input int short_col,
                             input int no_last_row, input int stall_row, input int stall_col,
                             input int defer_row, input int reset_row, input int reset_col);
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < LW; c++) begin
                logic          last;
                logic [DW-1:0] d;
                d = rnd ? DW'($urandom) : DW'(r);
                last = ((c == LW - 1) && (r != no_last_row)) || (r == short_row && c == short_col);
                if (rand_stall && $urandom_range(0, 15) == 0) stall_cycles($urandom_range(1, 2));
                send_beat(d, last);
                if (c == 0) row_cyc[r] = cyc;
                if (r == reset_row && c == reset_col) begin
                    do_reset();
                    return;
                end
                if (r == stall_row && c == stall_col) stall_cycles(5);
                if (last || c == LW - 1) begin
                    if (r == defer_row) stall_cycles(3);
                    check("err_len_row", err_len, m_err);
                    break;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_drain();
        check("frame_row_count", row_count, 0);
        check("frame_err_len", err_len, m_err);
    endtask

    // main sequence
    initial begin
        reset    = 1'b1;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        s_data   = '0;
        lb_ready = 1'b1;
        m_col    = 0;
        m_row    = 0;
        m_err    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", lb_we, 0);
        check("rst_eol", lb_eol, 0);
        check("rst_done", frame_done, 0);
        check("rst_rows", row_count, 0);
        check("rst_err", err_len, 0);
        check("rst_addr", lb_wr_addr, 0);
        check("rst_data", lb_data, 0);
        reset = 1'b0;

        // frame A: pixel = row, stall at row 1 col 37, eol deferred on row 5
        run_frame(1'b0, -1, -1, -1, 1, 37, 5, -1, -1);
        check("row0_cycles", row_cyc[1] - row_cyc[0], 101);
        check("row1_stall_cycles", row_cyc[2] - row_cyc[1], 106);
        check("row2_cycles", row_cyc[3] - row_cyc[2], 101);
        check("row5_defer_cycles", row_cyc[6] - row_cyc[5], 104);

        // frame B: random data and stalls, short row 3 (s_last at col 49)
        rand_stall = 1'b1;
        run_frame(1'b1, 3, 49, -1, -1, -1, -1, -1, -1);
        check("err_sticky", err_len, 1);

        // frame C: reset at row 7 col 60
        run_frame(1'b1, -1, -1, -1, -1, -1, -1, 7, 60);
        rand_stall = 1'b0;

        // frame D: missing s_last on row 2
        run_frame(1'b0, -1, -1, 2, -1, -1, -1, -1, -1);
        check("err_missing_last", err_len, 1);

        wait_drain();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
